// File: rtl/slot_bank_pkg.sv
// Shared types and constants for the slot bank arbiter: storage layout,
// header byte addresses and the address decode helper.
package slot_bank_pkg;

    localparam int NUM_LANES = 4;
    localparam int NUM_REQ   = 2;

    localparam logic [2:0] ADDR_MSB = 3'd4;
    localparam logic [2:0] ADDR_LSB = 3'd5;

    localparam logic [7:0] ERR_DATA = 8'hFF;

    typedef struct packed {
        logic [7:0]                      msb;
        logic [0:NUM_LANES-1][7:0]       data;
        logic [7:0]                      lsb;
    } slot_bank_t;

    typedef enum logic [1:0] {
        ACC_LANE = 2'd0,
        ACC_HDR  = 2'd1,
        ACC_BAD  = 2'd2
    } acc_kind_e;

    function automatic acc_kind_e decode_addr(input logic [2:0] addr);
        if (addr < 3'(NUM_LANES))
            return ACC_LANE;
        else if (addr == ADDR_MSB || addr == ADDR_LSB)
            return ACC_HDR;
        else
            return ACC_BAD;
    endfunction

endpackage

// File: rtl/slot_bank_arbiter_if.sv
// Two-requester request/response bus of the slot bank arbiter; the master
// side issues requests, the slave side grants them and returns responses.
interface slot_bank_arbiter_if;

    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [1:0][2:0] req_addr;
    logic [1:0][7:0] req_wdata;
    logic [1:0]      rsp_valid;
    logic [1:0][7:0] rsp_rdata;
    logic [1:0]      rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/slot_bank_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the favoured-requester pointer lives here and
// flips to the loser after every grant.
module rr_arb2 #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic ptr;

    // NOTE: grant gets a full default before the branches so no latch is inferred.
    always_comb begin
        grant = 2'b00;
        if (valid[ptr])
            grant[ptr] = 1'b1;
        else if (valid[~ptr])
            grant[~ptr] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= RR_INIT;
        else if (grant[0])
            ptr <= 1'b1;
        else if (grant[1])
            ptr <= 1'b0;
    end

endmodule

// File: rtl/slot_bank_arbiter.sv
// Round-robin shared register bank: four data lanes plus msb/lsb header bytes.
// Define SLOT_BANK_ERRCNT_EN to build the saturating error-response counter.
module slot_bank_arbiter
    import slot_bank_pkg::*;
#(
    parameter logic [7:0] FILL    = 8'hFF,
    parameter logic       RR_INIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    slot_bank_arbiter_if.slave    bus,
    output logic [7:0]            msb_o,
    output logic [7:0]            lsb_o,
    output logic [7:0]            err_cnt
);

    slot_bank_t bank;
    logic [1:0] grant;
    logic       accept;
    logic       sel;
    logic       acc_we;
    logic [2:0] acc_addr;
    logic [7:0] acc_wdata;
    acc_kind_e  acc_kind;
    logic       lane_wr;
    logic [7:0] rsp_data;
    logic       rsp_fail;

    rr_arb2 #(.RR_INIT(RR_INIT)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (bus.req_valid),
        .grant (grant)
    );

    assign bus.req_ready = grant;
    assign accept        = |grant;
    assign sel           = grant[1];
    assign acc_we        = bus.req_we[sel];
    assign acc_addr      = bus.req_addr[sel];
    assign acc_wdata     = bus.req_wdata[sel];
    assign acc_kind      = decode_addr(acc_addr);

    // Errors default to the fixed pattern so an invalid access never leaks X.
    always_comb begin
        rsp_data = ERR_DATA;
        rsp_fail = 1'b1;
        lane_wr  = 1'b0;
        case (acc_kind)
            ACC_LANE: begin
                rsp_fail = 1'b0;
                if (acc_we) begin
                    lane_wr  = accept;
                    rsp_data = acc_wdata;
                end else begin
                    rsp_data = bank.data[acc_addr[1:0]];
                end
            end
            ACC_HDR: begin
                if (!acc_we) begin
                    rsp_fail = 1'b0;
                    rsp_data = (acc_addr == ADDR_MSB) ? bank.msb : bank.lsb;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the bank is small register storage, so every byte is reset, not left uninitialised like a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank.msb  <= '0;
            bank.data <= {NUM_LANES{FILL}};
            bank.lsb  <= '0;
        end else if (lane_wr) begin
            bank.data[acc_addr[1:0]] <= acc_wdata;
            bank.msb                 <= bank.msb + 8'd1;
            bank.lsb                 <= {7'b0, sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= '0;
        end else begin
            bus.rsp_valid <= grant;
            if (accept) begin
                bus.rsp_rdata[sel] <= rsp_data;
                bus.rsp_err[sel]   <= rsp_fail;
            end
        end
    end

    assign msb_o = bank.msb;
    assign lsb_o = bank.lsb;

`ifdef SLOT_BANK_ERRCNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= '0;
        else if (accept && rsp_fail && err_q != 8'hFF)
            err_q <= err_q + 8'd1;
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_slot_bank_arbiter.sv
// Self-checking bench for slot_bank_arbiter: directed scenarios then random
// traffic, all compared against a behavioural model of the bank.
module tb_slot_bank_arbiter;

    logic clk;
    logic rst_n;
    logic [7:0] msb_o, lsb_o, err_cnt;

    slot_bank_arbiter_if bus();

    slot_bank_arbiter #(.FILL(8'hFF), .RR_INIT(1'b0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .msb_o   (msb_o),
        .lsb_o   (lsb_o),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    int m_lane [4];
    int m_msb, m_lsb, m_fav, m_errcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_lane[i] = 255;
        m_msb = 0;
        m_lsb = 0;
        m_fav = 0;
        m_errcnt = 0;
    endtask

    logic [1:0] last_grant;

    // Present a request set, check the grant, clock it, check the response.
    task automatic step(input logic [1:0] v, input logic [1:0] we,
                        input logic [2:0] a0, input logic [2:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1);
        logic [1:0] exp_g;
        int g, a, wd;
        logic wr;
        int exp_d;
        bit exp_e;
        bus.req_valid    = v;
        bus.req_we       = we;
        bus.req_addr[0]  = a0;
        bus.req_addr[1]  = a1;
        bus.req_wdata[0] = d0;
        bus.req_wdata[1] = d1;
        #1;
        exp_g = 2'b00;
        if (v == 2'b11) exp_g[m_fav] = 1'b1;
        else exp_g = v;
        check("req_ready", 32'(bus.req_ready), 32'(exp_g));
        last_grant = exp_g;
        g = -1;
        exp_d = 255;
        exp_e = 1'b1;
        if (exp_g != 2'b00) begin
            g  = exp_g[1] ? 1 : 0;
            a  = (g == 1) ? int'(a1) : int'(a0);
            wd = (g == 1) ? int'(d1) : int'(d0);
            wr = we[g];
            if (a < 4) begin
                exp_e = 1'b0;
                if (wr) begin
                    m_lane[a] = wd;
                    m_msb = (m_msb + 1) % 256;
                    m_lsb = g;
                    exp_d = wd;
                end else begin
                    exp_d = m_lane[a];
                end
            end else if (a == 4 && !wr) begin
                exp_e = 1'b0;
                exp_d = m_msb;
            end else if (a == 5 && !wr) begin
                exp_e = 1'b0;
                exp_d = m_lsb;
            end
`ifdef SLOT_BANK_ERRCNT_EN
            if (exp_e && m_errcnt < 255) m_errcnt++;
`endif
            m_fav = 1 - g;
        end
        @(posedge clk);
        #1;
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_g));
        if (g >= 0) begin
            check("rsp_rdata", 32'(bus.rsp_rdata[g]), 32'(exp_d));
            check("rsp_err", 32'(bus.rsp_err[g]), 32'(exp_e));
        end
        check("msb_o", 32'(msb_o), 32'(m_msb));
        check("lsb_o", 32'(lsb_o), 32'(m_lsb));
        check("err_cnt", 32'(err_cnt), 32'(m_errcnt));
    endtask

    task automatic idle();
        step(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
    endtask

    // Pending request per requester, held stable while it waits.
    logic [1:0] p_v, p_we;
    logic [2:0] p_a [2];
    logic [7:0] p_d [2];

    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset_msb", 32'(msb_o), 32'd0);
        check("reset_lsb", 32'(lsb_o), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First read after reset returns FILL
        step(2'b01, 2'b00, 3'd2, 3'd0, 8'h00, 8'h00);
        check("first_read_fill", 32'(bus.rsp_rdata[0]), 32'hFF);

        // Write then read back; neighbouring lane untouched
        step(2'b01, 2'b01, 3'd1, 3'd0, 8'h7E, 8'h00);
        step(2'b01, 2'b00, 3'd1, 3'd0, 8'h00, 8'h00);
        check("readback_lane1", 32'(bus.rsp_rdata[0]), 32'h7E);
        step(2'b01, 2'b00, 3'd2, 3'd0, 8'h00, 8'h00);
        check("readback_lane2", 32'(bus.rsp_rdata[0]), 32'hFF);
        check("hdr_msb_one", 32'(msb_o), 32'd1);
        check("hdr_lsb_zero", 32'(lsb_o), 32'd0);
        idle();

        // Contention: grants alternate starting from the favoured requester
        model_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 2'b00, 3'd0, 3'd3, 8'h00, 8'h00);
            check("alt_grant", 32'(last_grant), (i % 2 == 0) ? 32'd1 : 32'd2);
        end

        // Header read, header write and invalid address from requester 1
        step(2'b10, 2'b10, 3'd0, 3'd2, 8'h00, 8'h5A);
        step(2'b10, 2'b00, 3'd0, 3'd4, 8'h00, 8'h00);
        check("hdr_read_msb", 32'(bus.rsp_rdata[1]), 32'd1);
        step(2'b10, 2'b00, 3'd0, 3'd5, 8'h00, 8'h00);
        check("hdr_read_lsb", 32'(bus.rsp_rdata[1]), 32'd1);
        step(2'b10, 2'b10, 3'd0, 3'd5, 8'h00, 8'h33);
        check("hdr_write_err", 32'(bus.rsp_err[1]), 32'd1);
        step(2'b10, 2'b00, 3'd0, 3'd6, 8'h00, 8'h00);
        check("bad_addr_data", 32'(bus.rsp_rdata[1]), 32'hFF);
        step(2'b10, 2'b10, 3'd0, 3'd7, 8'h00, 8'h11);
        step(2'b10, 2'b00, 3'd0, 3'd2, 8'h00, 8'h00);
        check("lane2_after_errs", 32'(bus.rsp_rdata[1]), 32'h5A);

        // Reset right after an accept drops the response and restores state
        bus.req_valid = 2'b01;
        bus.req_we    = 2'b01;
        bus.req_addr[0]  = 3'd3;
        bus.req_wdata[0] = 8'hC3;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        model_reset();
        #1;
        check("rst_drop_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_msb", 32'(msb_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        idle();
        for (int i = 0; i < 4; i++)
            step(2'b01, 2'b00, 3'(i), 3'd0, 8'h00, 8'h00);

        // Random traffic with held requests for waiting requesters
        p_v = '0;
        p_we = '0;
        for (int r = 0; r < 2; r++) begin
            p_a[r] = '0;
            p_d[r] = '0;
        end
        last_grant = '0;
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!(p_v[r] && !last_grant[r])) begin
                    p_v[r]  = ($urandom_range(0, 3) != 0);
                    p_we[r] = $urandom_range(0, 1) != 0;
                    p_a[r]  = 3'($urandom_range(0, 7));
                    p_d[r]  = 8'($urandom);
                end
            end
            step(p_v, p_we, p_a[0], p_a[1], p_d[0], p_d[1]);
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
